// File: rtl/dtu_bpss_req_split.sv
// Splits one bypass descriptor into chunks that never cross a 2^BOUND_BITS-byte
// virtual-address boundary, emitting one chunk per downstream handshake.
module dtu_bpss_req_split #(
  parameter int VADDR_BITS = 48,
  parameter int LEN_BITS   = 28,
  parameter int PID_BITS   = 6,
  parameter int BOUND_BITS = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  input  logic [VADDR_BITS-1:0] s_req_vaddr,
  input  logic [LEN_BITS-1:0]   s_req_len,
  input  logic [PID_BITS-1:0]   s_req_pid,
  input  logic                  s_req_last,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [VADDR_BITS-1:0] m_req_vaddr,
  output logic [LEN_BITS-1:0]   m_req_len,
  output logic [PID_BITS-1:0]   m_req_pid,
  output logic                  m_req_first,
  output logic                  m_req_last,
  output logic                  busy,
  output logic [31:0]           chunk_cnt
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                state, state_nxt;
  logic [VADDR_BITS-1:0] cur_addr;
  logic [LEN_BITS-1:0]   rem_len;
  logic [PID_BITS-1:0]   pid_q;
  logic                  last_q;
  logic                  first_q;

  logic [BOUND_BITS:0]   room;
  logic [LEN_BITS-1:0]   room_ext;
  logic [LEN_BITS-1:0]   chunk;
  logic                  is_final;
  logic                  active;
  logic                  s_hs;
  logic                  m_hs;

  function automatic logic [LEN_BITS-1:0] min_len(input logic [LEN_BITS-1:0] a,
                                                  input logic [LEN_BITS-1:0] b);
    return (a <= b) ? a : b;
  endfunction

  // Bytes left before the next boundary; only the low address bits matter,
  // so a descriptor running past the top of the address space splits at the wrap.
  assign room     = {1'b1, {BOUND_BITS{1'b0}}} - {1'b0, cur_addr[BOUND_BITS-1:0]};
  assign room_ext = {{(LEN_BITS-BOUND_BITS-1){1'b0}}, room};
  assign chunk    = min_len(rem_len, room_ext);
  assign is_final = (rem_len <= room_ext);

  assign active      = (state == SPLIT) && !areset;
  assign s_req_ready = (state == IDLE) && !areset;
  assign s_hs        = s_req_valid && s_req_ready;
  assign m_hs        = m_req_valid && m_req_ready;

  assign m_req_valid = active;
  assign m_req_vaddr = active ? cur_addr : '0;
  assign m_req_len   = active ? chunk : '0;
  assign m_req_pid   = active ? pid_q : '0;
  assign m_req_first = active && first_q;
  assign m_req_last  = active && is_final && last_q;
  assign busy        = (state == SPLIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_hs) state_nxt = SPLIT;
      SPLIT:   if (m_hs && is_final) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      chunk_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (m_hs) chunk_cnt <= chunk_cnt + 32'd1;
    end
  end

  // Descriptor registers carry no reset: every output they feed is gated by state.
  always_ff @(posedge aclk) begin
    if (s_hs) begin
      cur_addr <= s_req_vaddr;
      rem_len  <= s_req_len;
      pid_q    <= s_req_pid;
      last_q   <= s_req_last;
      first_q  <= 1'b1;
    end else if (m_hs && !is_final) begin
      cur_addr <= cur_addr + {{(VADDR_BITS-LEN_BITS){1'b0}}, chunk};
      rem_len  <= rem_len - chunk;
      first_q  <= 1'b0;
    end
  end

endmodule
